mips_dmem_dump: RTL and testbench

Debug readback engine for the MIPS_64 data memory: on request, it waits for the processor to halt and then reads a contiguous range of DATA_MEMORY words through a synchronous read port. Each word is streamed out with its address over a valid/ready interface. It is the read-side counterpart of the bench-side memory preload: benches and the debug host retrieve program results (e.g. words 120/121 after a store sequence) through this block instead of hierarchical peeks.

---
 rtl/mips_dmem_dump_if.sv | 24 ++
 rtl/mips_dmem_dump.sv | 109 ++++++++++
 tb/tb_mips_dmem_dump.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_dump_if.sv
// Memory read port plus beat stream of the data-memory dump engine.
// master = dump engine, slave = memory/sink side.
interface mips_dmem_dump_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
    input  mem_rdata, out_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/mips_dmem_dump.sv
// Debug readback of a contiguous DATA_MEMORY range once the core halts;
// one word per RD/LATCH/SEND round trip, streamed with its address.
module mips_dmem_dump #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              halted_i,
  mips_dmem_dump_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HALT, S_RD, S_LATCH, S_SEND, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              abort_q, abort_d;

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    data_d        = data_q;
    addr_d        = addr_q;
    last_d        = last_q;
    abort_d       = abort_q;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          ptr_d = base_addr;
          rem_d = count;
          if (count == '0)   state_d = S_FIN;
          else if (halted_i) state_d = S_RD;
          else               state_d = S_WAIT_HALT;
        end
      end
      S_WAIT_HALT: if (halted_i) state_d = S_RD;
      S_RD: begin
        // Core resumed between beats: stop without touching memory.
        if (halted_i) begin
          bus.mem_rd_en = 1'b1;
          bus.mem_addr  = ptr_q;
          state_d       = S_LATCH;
        end else begin
          abort_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_LATCH: begin
        data_d  = bus.mem_rdata;
        addr_d  = ptr_q;
        last_d  = (rem_q == (ADDR_W+1)'(1));
        state_d = S_SEND;
      end
      S_SEND: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = last_q ? S_FIN : S_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_data = data_q;
  assign bus.out_addr = addr_q;
  assign bus.out_last = last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign aborted      = done && abort_q;
endmodule

// File: tb/tb_mips_dmem_dump.sv
// Directed bench for mips_dmem_dump: bench-side memory, expected-beat
// queue built from the memory contents, per-cycle compare process.
module tb_mips_dmem_dump;
  logic        clk1 = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        halted_i;
  logic        busy, done, aborted;

  mips_dmem_dump_if #(.DATA_W(64), .ADDR_W(10)) bus ();

  mips_dmem_dump #(.DATA_W(64), .ADDR_W(10)) dut (
    .clk1(clk1), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .halted_i(halted_i), .bus(bus),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk1 = ~clk1;

  logic [63:0] mem [1024];
  always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  typedef struct { logic [9:0] a; logic [63:0] d; logic l; } beat_t;
  beat_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int beats, reads, done_cnt, done_cyc, first_valid, stalls, e_cyc;
  logic exp_abort;
  logic [63:0] last_data;
  logic [9:0]  last_addr;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [9:0]  prev_a;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every beat against the queue head, reads against the
  // next expected address, stability under backpressure, done/aborted.
  always @(negedge clk1) begin
    if (!reset) begin
      if (bus.mem_rd_en) begin
        reads++;
        chk("rd_while_running", {63'd0, halted_i}, 64'd1);
        if (exp_q.size() > 0) chk("rd_addr", {54'd0, bus.mem_addr}, {54'd0, exp_q[0].a});
        else chk("rd_unexpected", {63'd0, bus.mem_rd_en}, 64'd0);
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          chk("stall_data", bus.out_data, prev_d);
          chk("stall_addr", {54'd0, bus.out_addr}, {54'd0, prev_a});
        end
        if (exp_q.size() == 0) chk("beat_extra", {63'd0, bus.out_valid}, 64'd0);
        else begin
          chk("beat_addr", {54'd0, bus.out_addr}, {54'd0, exp_q[0].a});
          chk("beat_data", bus.out_data, exp_q[0].d);
          chk("beat_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].l});
          if (bus.out_ready) begin
            last_data = bus.out_data;
            last_addr = bus.out_addr;
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (bus.out_valid && !bus.out_ready) stalls++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_a     = bus.out_addr;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("aborted", {63'd0, aborted}, {63'd0, exp_abort});
      end
    end else prev_stall = 1'b0;
  end

  task automatic do_start(input logic [9:0] b, input int n, input logic ab);
    beat_t x;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      x.a = b + 10'(i);
      x.d = mem[x.a];
      x.l = (i == n - 1);
      exp_q.push_back(x);
    end
    beats = 0; reads = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
    stalls = 0; exp_abort = ab;
    @(negedge clk1);
    start = 1'b1; base_addr = b; count = 11'(n);
    @(posedge clk1); #1;
    start = 1'b0;
    e_cyc = cyc;
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(posedge clk1); #1;
      k++;
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    halted_i = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = {32'hA5A5_0000, 22'd0, 10'(i)};
    mem[120] = 64'd85;  mem[121] = 64'd130;
    mem[1023] = 64'd7;  mem[0] = 64'd8;  mem[1] = 64'd9;
    mem[300] = 64'hDEAD_BEEF_0000_0001;  mem[301] = 64'hCAFE_F00D_1234_5678;
    repeat (3) @(posedge clk1);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_mem_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    reset = 1'b0;
    @(posedge clk1); #1;

    // words 120/121, halted, sink always ready
    do_start(10'd120, 2, 1'b0);
    wait_done(50);
    chk("t1_beats", 64'(beats), 64'd2);
    chk("t1_reads", 64'(reads), 64'd2);
    chk("t1_first_valid", 64'(first_valid - e_cyc), 64'd2);
    chk("t1_done_cyc", 64'(done_cyc - e_cyc), 64'd6);
    chk("t1_last_data", last_data, 64'd85 + 64'd45);
    chk("t1_last_addr", {54'd0, last_addr}, 64'd121);
    chk("t1_busy_fall", {63'd0, busy}, 64'd0);

    // halt arrives 10 cycles late
    halted_i = 1'b0;
    do_start(10'd120, 2, 1'b0);
    repeat (10) begin
      @(posedge clk1); #1;
      chk("t2_busy_wait", {63'd0, busy}, 64'd1);
      chk("t2_no_read", {63'd0, bus.mem_rd_en}, 64'd0);
    end
    halted_i = 1'b1;
    wait_done(50);
    chk("t2_beats", 64'(beats), 64'd2);
    chk("t2_last_data", last_data, 64'd130);

    // address wrap 1023 -> 0 -> 1
    do_start(10'd1023, 3, 1'b0);
    wait_done(50);
    chk("t3_beats", 64'(beats), 64'd3);
    chk("t3_last_addr", {54'd0, last_addr}, 64'd1);
    chk("t3_last_data", last_data, 64'd9);
    chk("t3_done_cyc", 64'(done_cyc - e_cyc), 64'd9);

    // out_ready toggling every cycle
    do_start(10'd300, 2, 1'b0);
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      bus.out_ready = ~bus.out_ready;
      @(posedge clk1); #1;
    end
    bus.out_ready = 1'b1;
    chk("t4_done", 64'(done_cnt), 64'd1);
    chk("t4_beats", 64'(beats), 64'd2);
    chk("t4_stalled", {63'd0, stalls > 0}, 64'd1);
    chk("t4_last_data", last_data, 64'hCAFE_F00D_1234_5678);

    // halt drops after the second handshake
    do_start(10'd200, 4, 1'b1);
    for (int k = 0; k < 50 && beats < 2; k++) begin
      @(posedge clk1); #1;
    end
    halted_i = 1'b0;
    wait_done(50);
    repeat (3) @(posedge clk1);
    #1;
    chk("t5_beats", 64'(beats), 64'd2);
    chk("t5_reads", 64'(reads), 64'd2);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    halted_i = 1'b1;

    // empty dump
    do_start(10'd5, 0, 1'b0);
    wait_done(10);
    chk("t6_done_cyc", 64'(done_cyc - e_cyc), 64'd0);
    chk("t6_beats", 64'(beats), 64'd0);
    chk("t6_reads", 64'(reads), 64'd0);
    chk("t6_no_valid", {63'd0, first_valid < 0}, 64'd1);

    // reset while a beat sits in SEND
    bus.out_ready = 1'b0;
    do_start(10'd120, 2, 1'b0);
    for (int k = 0; k < 20 && !bus.out_valid; k++) begin
      @(posedge clk1); #1;
    end
    chk("t7_in_send", {63'd0, bus.out_valid}, 64'd1);
    reset = 1'b1;
    @(posedge clk1); #1;
    chk("t7_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_done", {63'd0, done}, 64'd0);
    chk("t7_data", bus.out_data, 64'd0);
    chk("t7_addr", {54'd0, bus.out_addr}, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk1);
    #1;
    chk("t7_no_done", 64'(done_cnt), 64'd0);
    chk("t7_idle", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
